mac_array_stream: RTL and testbench

//  Parametrised successor to the 8-lane B-broadcast MAC array. Computes N dot products of

---
 rtl/mac_array_stream.sv | 191 +++++++++++++++++++
 tb/tb_mac_array_stream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_stream.sv
// Streaming B-broadcast MAC array: N lanes compute dot products of length len against one
// shared B stream, with A skewed per lane so lane i meets its operand at B pipe stage i.

module mac_array_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int SIGNED     = 0,
  parameter int DEPTH      = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic                  i_sat,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_acc,
  output logic                  o_ovf
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 1;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_skew;
  logic [ACC_WIDTH-1:0]             r_acc;
  logic                             r_ovf;
  logic [DATA_WIDTH-1:0]            w_a;
  logic [SW-1:0]                    w_sum;
  logic                             w_ovf;
  logic [ACC_WIDTH-1:0]             w_clamp;
  logic [ACC_WIDTH-1:0]             w_next;

  assign w_a = r_skew[DEPTH-1];

  // Sum is one bit wider than the accumulator so overflow is visible before clamping.
  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [PW-1:0] w_prod;
      assign w_prod  = PW'($signed(w_a)) * PW'($signed(i_b));
      assign w_sum   = SW'($signed(r_acc)) + SW'(w_prod);
      assign w_ovf   = w_sum[SW-1] ^ w_sum[SW-2];
      assign w_clamp = w_sum[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin : g_unsigned
      logic [PW-1:0] w_prod;
      assign w_prod  = PW'(w_a) * PW'(i_b);
      assign w_sum   = SW'(r_acc) + SW'(w_prod);
      assign w_ovf   = w_sum[SW-1];
      assign w_clamp = '1;
    end
  endgenerate

  assign w_next = (w_ovf && i_sat) ? w_clamp : w_sum[ACC_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_skew <= '0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_skew[0] <= i_a;
      for (int k = 1; k < DEPTH; k++) r_skew[k] <= r_skew[k-1];
      if (i_clr) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (i_en) begin
        r_acc <= w_next;
        r_ovf <= r_ovf | w_ovf;
      end
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;
endmodule

module mac_array_stream #(
  parameter  int DATA_WIDTH = 8,
  parameter  int N          = 8,
  parameter  int ACC_WIDTH  = 24,
  parameter  int K_MAX      = 256,
  parameter  int SIGNED     = 0,
  localparam int LW         = $clog2(K_MAX + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [LW-1:0]           i_len,
  input  logic                    i_sat_en,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [DATA_WIDTH-1:0]   i_b_in,
  input  logic [N*DATA_WIDTH-1:0] i_a_in,
  output logic [N*ACC_WIDTH-1:0]  o_c_out,
  output logic [N-1:0]            o_ovf,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_busy
);
  localparam int DCW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                            r_state, w_next;
  logic [LW-1:0]                     r_rem;
  logic [DCW-1:0]                    r_dcnt;
  logic                              r_sat;
  logic [N-1:0][DATA_WIDTH-1:0]      r_b_pipe;
  logic [N-1:0]                      r_vld_pipe;
  logic [N-1:0][DATA_WIDTH-1:0]      w_a;
  logic [N-1:0][ACC_WIDTH-1:0]       w_acc;
  logic                              w_accept;
  logic                              w_clr;

  assign w_a      = i_a_in;
  assign w_accept = i_in_valid && (r_state == S_RUN);

  always_comb begin
    w_next      = r_state;
    w_clr       = 1'b0;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_clr  = 1'b1;
          w_next = (i_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        o_in_ready = 1'b1;
        if (w_accept && r_rem == LW'(1)) w_next = S_DRAIN;
      end
      // Final beat needs N more edges to reach lane N-1's accumulator, plus one to settle.
      S_DRAIN: if (r_dcnt == DCW'(N)) w_next = S_DONE;
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_dcnt     <= '0;
      r_sat      <= 1'b0;
      r_b_pipe   <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) begin
        r_rem <= i_len;
        r_sat <= i_sat_en;
      end else if (w_accept) begin
        r_rem <= r_rem - LW'(1);
      end
      r_dcnt        <= (r_state == S_DRAIN) ? r_dcnt + DCW'(1) : '0;
      r_b_pipe[0]   <= i_b_in;
      r_vld_pipe[0] <= w_accept;
      for (int k = 1; k < N; k++) begin
        r_b_pipe[k]   <= r_b_pipe[k-1];
        r_vld_pipe[k] <= r_vld_pipe[k-1];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mac_array_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SIGNED     (SIGNED),
      .DEPTH      (i + 1)
    ) u_lane (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_clr),
      .i_en  (r_vld_pipe[i]),
      .i_sat (r_sat),
      .i_a   (w_a[i]),
      .i_b   (r_b_pipe[i]),
      .o_acc (w_acc[i]),
      .o_ovf (o_ovf[i])
    );
  end

  assign o_c_out = w_acc;
endmodule

// File: tb/tb_mac_array_stream.sv
// Scoreboarded bench: unsigned/24-bit and signed/16-bit arrays share one stimulus stream and
// are checked against a per-beat arithmetic reference model.
module tb_mac_array_stream;
  localparam int DW = 8, N = 8, AW0 = 24, AW1 = 16, KM = 256, LW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, sat, in_valid, out_ready;
  logic [LW-1:0]    len_in;
  logic [DW-1:0]    b_in;
  logic [N*DW-1:0]  a_in;
  logic             ir0, ir1, ov0, ov1, busy0, busy1;
  logic [N*AW0-1:0] c0;
  logic [N*AW1-1:0] c1;
  logic [N-1:0]     f0, f1;

  mac_array_stream #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(AW0), .K_MAX(KM), .SIGNED(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len_in), .i_sat_en(sat),
    .i_in_valid(in_valid), .o_in_ready(ir0), .i_b_in(b_in), .i_a_in(a_in),
    .o_c_out(c0), .o_ovf(f0), .o_out_valid(ov0), .i_out_ready(out_ready), .o_busy(busy0));

  mac_array_stream #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(AW1), .K_MAX(KM), .SIGNED(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len_in), .i_sat_en(sat),
    .i_in_valid(in_valid), .o_in_ready(ir1), .i_b_in(b_in), .i_a_in(a_in),
    .o_c_out(c1), .o_ovf(f1), .o_out_valid(ov1), .i_out_ready(out_ready), .o_busy(busy1));

  typedef struct {
    logic [N*AW0-1:0] c0;
    logic [N-1:0]     v0;
    logic [N*AW1-1:0] c1;
    logic [N-1:0]     v1;
    int               lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [DW-1:0] ad [KM][N];
  logic [DW-1:0] bd [KM];
  int errors = 0, checks = 0;
  int cyc = 0, ref_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0 random, 1 a=i+1/b=k+1, 2 all 0x80, 3 all 0xFF
  task automatic gen(input int mode, input int n);
    for (int k = 0; k < n; k++) begin
      bd[k] = (mode == 1) ? DW'(k + 1) : (mode == 2) ? 8'h80 : (mode == 3) ? 8'hFF : DW'($urandom);
      for (int i = 0; i < N; i++)
        ad[k][i] = (mode == 1) ? DW'(i + 1) : (mode == 2) ? 8'h80 : (mode == 3) ? 8'hFF : DW'($urandom);
    end
  endtask

  function automatic exp_t model(input int n, input bit s);
    exp_t e;
    longint acc, p;
    logic [15:0] t;
    e.lat = (n == 0) ? 0 : N + 1;
    e.v0 = '0;
    e.v1 = '0;
    for (int i = 0; i < N; i++) begin
      acc = 0;
      for (int k = 0; k < n; k++) begin
        p = longint'(ad[k][i]) * longint'(bd[k]);
        acc = acc + p;
        if (acc > 64'd16777215) begin
          e.v0[i] = 1'b1;
          acc = s ? 64'd16777215 : acc % 64'd16777216;
        end
      end
      e.c0[i*AW0 +: AW0] = acc[AW0-1:0];
      acc = 0;
      for (int k = 0; k < n; k++) begin
        p = longint'($signed(ad[k][i])) * longint'($signed(bd[k]));
        acc = acc + p;
        if (acc > 32767 || acc < -32768) begin
          e.v1[i] = 1'b1;
          if (s) acc = (acc > 0) ? 32767 : -32768;
          else begin
            t = acc[15:0];
            acc = longint'($signed(t));
          end
        end
      end
      e.c1[i*AW1 +: AW1] = acc[AW1-1:0];
    end
    return e;
  endfunction

  task automatic drive_beat(input bit v, input int k);
    in_valid = v;
    b_in = v ? bd[k] : DW'($urandom);
    for (int i = 0; i < N; i++) a_in[i*DW +: DW] = v ? ad[k][i] : DW'($urandom);
  endtask

  // bmode: 0 no bubbles, 1 bubble every other cycle, 2 random 30% bubbles
  task automatic run_job(input int n, input bit s, input int bmode, input int hold);
    exp_t e;
    bit v, acc;
    int k, guard;
    e = model(n, s);
    exp_q.push_back(e);
    out_ready = (hold == 0);
    start = 1'b1; len_in = LW'(n); sat = s;
    step();
    start = 1'b0;
    if (n == 0) begin
      ref_cyc = cyc;
      chk("len0_in_ready", 256'(ir0), 256'(0));
    end
    k = 0; guard = 0;
    while (k < n && guard < 20000) begin
      v = (bmode == 0) ? 1'b1 : (bmode == 1) ? (guard % 2 == 0) : ($urandom_range(99) >= 30);
      drive_beat(v, k);
      acc = v && ir0;
      step();
      guard++;
      if (acc) begin
        k++;
        if (k == n) ref_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    if (k < n) chk("beat_timeout", 256'(k), 256'(n));
    if (hold > 0) begin
      guard = 0;
      while (!ov0 && guard < 2000) begin step(); guard++; end
      chk("wait_out_valid", 256'(ov0), 256'(1));
      repeat (hold) begin
        start = 1'($urandom_range(1));
        len_in = LW'($urandom);
        step();
      end
      start = 1'b0;
      out_ready = 1'b1;
    end
    guard = 0;
    while (busy0 && guard < 2000) begin step(); guard++; end
    if (busy0) chk("idle_timeout", 256'(busy0), 256'(0));
    out_ready = 1'b0;
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_busy"}, 256'(busy0), 256'(0));
    chk({nm, "_in_ready"}, 256'(ir0), 256'(0));
    chk({nm, "_out_valid"}, 256'(ov0), 256'(0));
    chk({nm, "_c0"}, 256'(c0), 256'(0));
    chk({nm, "_ovf0"}, 256'(f0), 256'(0));
    chk({nm, "_c1"}, 256'(c1), 256'(0));
    chk({nm, "_ovf1"}, 256'(f1), 256'(0));
  endtask

  exp_t cur;
  bit   have = 1'b0, pv = 1'b0;

  always @(negedge clk) begin
    if (ov0 && !pv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: out_valid rose with no job outstanding");
        have = 1'b0;
      end else begin
        cur = exp_q.pop_front();
        have = 1'b1;
        chk("latency", 256'(cyc - ref_cyc), 256'(cur.lat));
        chk("out_valid1", 256'(ov1), 256'(1));
        chk("busy1_done", 256'(busy1), 256'(1));
        chk("in_ready1_done", 256'(ir1), 256'(0));
      end
    end
    if (ov0 && have) begin
      chk("c_out0", 256'(c0), 256'(cur.c0));
      chk("ovf0", 256'(f0), 256'(cur.v0));
      chk("c_out1", 256'(c1), 256'(cur.c1));
      chk("ovf1", 256'(f1), 256'(cur.v1));
    end
    pv = ov0;
  end

  initial begin
    rst = 1'b1; start = 1'b0; sat = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len_in = '0; b_in = '0; a_in = '0;
    repeat (3) step();
    chk_cleared("reset");
    rst = 1'b0;
    step();

    gen(1, 4); run_job(4, 1'b0, 0, 0);
    gen(1, 4); run_job(4, 1'b0, 1, 0);
    gen(2, 4); run_job(4, 1'b1, 0, 0);
    gen(2, 4); run_job(4, 1'b0, 0, 0);
    run_job(0, 1'b0, 0, 0);
    run_job(0, 1'b1, 0, 3);
    gen(0, 6); run_job(6, 1'b0, 2, 10);
    gen(0, 1); run_job(1, 1'b1, 0, 0);

    // abandon a job two beats in
    gen(0, 8);
    out_ready = 1'b0;
    start = 1'b1; len_in = LW'(8); sat = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin drive_beat(1'b1, k); step(); end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cleared("midjob_reset");
    gen(0, 8); run_job(8, 1'b1, 2, 0);

    gen(3, KM); run_job(KM, 1'b1, 0, 1);
    gen(0, KM); run_job(KM, 1'b0, 2, 0);

    repeat (40) begin
      int n;
      n = $urandom_range(24, 1);
      gen(0, n);
      run_job(n, 1'($urandom_range(1)), 2, $urandom_range(3));
    end

    repeat (3) step();
    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
